// File: rtl/mips_trace_buffer.sv
// Retirement-trace capture: circular buffer with PC-match trigger, post-trigger window,
// optional nop filtering, and a valid/ready drain port once capture has frozen.
module mips_trace_buffer #(
  parameter int unsigned PC_W      = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned POST_TRIG = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arm,
  input  logic                     in_valid,
  input  logic [PC_W-1:0]          in_pc,
  input  logic [31:0]              in_instr,
  input  logic [DATA_W-1:0]        in_wb,
  input  logic                     skip_nop,
  input  logic                     trig_en,
  input  logic [PC_W-1:0]          trig_pc,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [PC_W-1:0]          out_pc,
  output logic [31:0]              out_instr,
  output logic [DATA_W-1:0]        out_wb,
  output logic                     out_last,
  output logic [1:0]               state_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = PC_W + 32 + DATA_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_POST  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [AW-1:0] POST_INIT = AW'(POST_TRIG);
  localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);

  logic [1:0]    r_state, r_state_d;
  logic [CW-1:0] r_count, r_count_d;
  logic [AW-1:0] r_wr_ptr, r_wr_ptr_d;
  logic [AW-1:0] r_rd_ptr, r_rd_ptr_d;
  logic [AW-1:0] r_post, r_post_d;
  logic          r_overflow, r_overflow_d;
  logic [EW-1:0] r_mem [DEPTH];

  logic          w_capturing, w_store, w_full, w_trig, w_pop, w_go_done;
  logic [AW-1:0] w_wr_ptr_nxt;
  logic [CW-1:0] w_count_inc;
  logic [EW-1:0] w_entry;

  assign w_capturing  = (r_state == S_ARMED) || (r_state == S_POST);
  assign w_store      = in_valid && !(skip_nop && (in_instr == '0)) && w_capturing && !arm;
  assign w_full       = (r_count == COUNT_MAX);
  assign w_trig       = w_store && (r_state == S_ARMED) && trig_en && (in_pc == trig_pc);
  assign w_pop        = out_valid && out_ready;
  assign w_wr_ptr_nxt = r_wr_ptr + AW'(1);
  assign w_count_inc  = w_full ? r_count : r_count + CW'(1);
  assign w_go_done    = (w_trig && (POST_TRIG == 0)) ||
                        ((r_state == S_POST) && w_store && (r_post == AW'(1)));

  always_comb begin
    r_state_d    = r_state;
    r_count_d    = r_count;
    r_wr_ptr_d   = r_wr_ptr;
    r_rd_ptr_d   = r_rd_ptr;
    r_post_d     = r_post;
    r_overflow_d = r_overflow;
    if (arm) begin
      r_state_d    = S_ARMED;
      r_count_d    = '0;
      r_wr_ptr_d   = '0;
      r_rd_ptr_d   = '0;
      r_post_d     = '0;
      r_overflow_d = 1'b0;
    end else if (r_state == S_DONE) begin
      if (w_pop) begin
        r_rd_ptr_d = r_rd_ptr + AW'(1);
        r_count_d  = r_count - CW'(1);
      end
    end else if (w_store) begin
      r_wr_ptr_d = w_wr_ptr_nxt;
      r_count_d  = w_count_inc;
      if (w_full) r_overflow_d = 1'b1;
      if (r_state == S_POST) r_post_d = r_post - AW'(1);
      if (w_go_done) begin
        r_state_d  = S_DONE;
        // Oldest surviving entry; a full buffer wraps back onto the write pointer.
        r_rd_ptr_d = w_wr_ptr_nxt - w_count_inc[AW-1:0];
      end else if (w_trig) begin
        r_state_d = S_POST;
        r_post_d  = POST_INIT;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_post     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= r_state_d;
      r_count    <= r_count_d;
      r_wr_ptr   <= r_wr_ptr_d;
      r_rd_ptr   <= r_rd_ptr_d;
      r_post     <= r_post_d;
      r_overflow <= r_overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_store) r_mem[r_wr_ptr] <= {in_pc, in_instr, in_wb};
  end

  assign w_entry   = r_mem[r_rd_ptr];
  assign out_valid = (r_state == S_DONE) && (r_count != '0);
  assign out_pc    = out_valid ? w_entry[EW-1 -: PC_W] : '0;
  assign out_instr = out_valid ? w_entry[DATA_W +: 32] : '0;
  assign out_wb    = out_valid ? w_entry[DATA_W-1:0] : '0;
  assign out_last  = out_valid && (r_count == CW'(1));
  assign state_o   = r_state;
  assign count_o   = r_count;
  assign overflow  = r_overflow;

endmodule

// File: doc/mips_trace_buffer.md
Name: mips_trace_buffer

Overview:
- Synthesizable, parametrised retirement-trace capture unit for the MIPS core.
- Replaces ad-hoc per-cycle printing of PC, instruction and writeback data with an on-chip circular buffer.
- Features: PC-match trigger, post-trigger capture window, bubble filtering, and a valid/ready readout port.
- Sits beside the core's writeback stage; a bench or debug host drains it after it freezes.

Parameters:
PC_W, 32, width of captured PC
DATA_W, 32, width of captured writeback data
DEPTH, 16, entries in buffer; power of 2, >= 2
POST_TRIG, 8, entries captured after the trigger entry; 0 <= POST_TRIG < DEPTH

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset (asserted at 0)
arm  in  1  pulse: clear buffer and start capturing
in_valid  in  1  a retired instruction is presented this cycle
in_pc  in  PC_W  PC of retired instruction
in_instr  in  32  instruction word
in_wb  in  DATA_W  writeback data
skip_nop  in  1  when 1, entries with in_instr==0 are not stored
trig_en  in  1  enable PC-match trigger
trig_pc  in  PC_W  trigger PC
out_ready  in  1  consumer accepts readout entry
out_valid  out  1  readout entry available
out_pc  out  PC_W  readout PC
out_instr  out  32  readout instruction
out_wb  out  DATA_W  readout writeback data
out_last  out  1  current readout entry is the final one
state_o  out  2  0=IDLE 1=ARMED 2=POST 3=DONE
count_o  out  clog2(DEPTH)+1  valid entries held
overflow  out  1  sticky: an entry was overwritten since arm

Behaviour:
- Reset (reset==0, async):
  - state IDLE; count 0; wr_ptr and rd_ptr 0; post counter 0; overflow 0; out_valid 0.
  - out_* data forced to 0 whenever out_valid==0.
  - Memory is not reset.
- Store condition: stores = in_valid && !(skip_nop && in_instr==0) && state in {ARMED, POST} && !arm.
- Each store:
  - Write mem[wr_ptr] = {in_pc, in_instr, in_wb}.
  - wr_ptr increments, wrapping modulo DEPTH.
  - count increments, saturating at DEPTH; a store while count==DEPTH sets overflow (oldest entry lost).
- arm (any state, highest priority):
  - Next cycle: state ARMED, count 0, wr_ptr 0, rd_ptr 0, overflow 0.
  - An input entry presented in the same cycle is dropped.
- IDLE: no capture; waits for arm.
- ARMED: circular capture.
  - A stored entry with trig_en && in_pc==trig_pc is the trigger entry; it is stored.
  - On the trigger entry: if POST_TRIG==0, go to DONE; else load post counter = POST_TRIG and go to POST.
  - Filtered (skipped) entries never trigger.
- POST: each store decrements the post counter; the store taking it to 0 moves state to DONE the next cycle. Trigger matches are ignored in POST.
- DONE: capture frozen.
  - On entry, rd_ptr = (wr_ptr - count) mod DEPTH, i.e. the oldest entry.
  - out_valid = (count>0); out_* driven combinationally from mem[rd_ptr].
  - out_last = (count==1).
  - On out_valid && out_ready: rd_ptr++ (wrap), count--. The next entry appears the following cycle, so zero-bubble streaming runs at 1 entry/cycle.
  - When count reaches 0, out_valid drops and state stays DONE until arm.
- Latency: input to stored is 1 cycle. Trigger entry to DONE is POST_TRIG qualifying stores plus 1 cycle.
- Reset mid-readout or mid-capture: immediate return to IDLE; partial data is discarded from the visible count.
- count_o reflects live count in all states; state_o is the registered state.

Test Plan:
- Reset release, no arm; 5 valid retirements -> state_o=0, count_o=0, out_valid=0 throughout.
- arm; trig_pc=0x10, trig_en=1, POST_TRIG=8, DEPTH=16; PCs 0x00,0x04,...,0x40 stream (17 valid) -> trigger at 0x10; DONE after PC 0x30 stored; count=13; readout with out_ready=1 yields PCs 0x00..0x30 in order, out_last on 0x30, overflow=0.
- DEPTH=16; arm; 20 entries with PCs 0..19, trig at PC 19, POST_TRIG=0 -> overflow=1, count=16, readout starts PC 4, ends PC 19 with out_last.
- skip_nop=1; stream instr 0x00000000 interleaved with nonzero words; trig_pc equals a nop's PC -> nops not stored and no trigger; count equals the number of nonzero entries.
- Readout with out_ready toggling 1,0,0,1 -> each entry held stable while out_ready=0, with no skip or duplicate.
- Assert reset=0 mid-POST, then release and arm -> state IDLE then ARMED, count 0, overflow 0; arm asserted with in_valid in the same cycle -> that entry is not stored.
